// File: rtl/seven_segment_to_priority_decoder_pkg.sv
// Shared constants and types for the 7-segment to priority-index decoder.
// Holds the legal code table, the none pattern, the reset token for `last`, and the FSM state enum.
package seg_dec_pkg;

  // Entry i is the gfedcba code displayed for priority index i.
  localparam logic [7:0][6:0] SEG_CODES = {
    7'b0000111, 7'b1111101, 7'b1101101, 7'b1100110,
    7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
  };

  localparam logic [7:0] NONE_PAT   = 8'b1000_0000;  // {none, gfedcba}
  // Bit 8 set: never equal to a real 8-bit sample, so the first stable pattern is always new.
  localparam logic [8:0] LAST_TOKEN = 9'h100;

  typedef enum logic {
    TRACK,
    EMIT
  } state_e;

  typedef struct packed {
    logic       legal;
    logic       is_none;
    logic [2:0] index;
  } dec_t;

  function automatic dec_t seg_decode(input logic [7:0] pat);
    dec_t r;
    r = '0;
    if (pat == NONE_PAT) begin
      r.legal   = 1'b1;
      r.is_none = 1'b1;
    end else if (!pat[7]) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (pat[6:0] == SEG_CODES[i]) begin
          r.legal = 1'b1;
          r.index = 3'(i);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seven_segment_to_priority_decoder_if.sv
// Valid/ready output port carrying the decoded priority word.
// The decoder drives it through the master modport; the consumer uses the slave modport.
interface seven_segment_to_priority_decoder_if;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] index;
  logic [7:0] data;
  logic       is_none;

  modport master (output out_valid, output index, output data, output is_none, input out_ready);
  modport slave  (input out_valid, input index, input data, input is_none, output out_ready);
endinterface

// File: rtl/seven_segment_to_priority_decoder_filter.sv
// seg_stable_filter: optional 2-flop synchronizer (SEGDEC_SYNC_EN), sample register S,
// saturating stability counter and last-accepted pattern; strobes `accept` with the pattern.
module seg_stable_filter
  import seg_dec_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] segments,
  input  logic       none,
  output logic       accept,
  output logic [7:0] pattern
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  logic [7:0] sample;

`ifdef SEGDEC_SYNC_EN
  logic [7:0] sync1_q, sync1_d, sync2_q, sync2_d;

  always_comb begin
    sync1_d = {none, segments};
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign sample = sync2_q;
`else
  assign sample = {none, segments};
`endif

  logic [7:0] s_q, s_d;
  logic [7:0] cnt_q, cnt_d;
  logic [8:0] last_q, last_d;

  // Acceptance is judged on the next-state values so the top can register the
  // word on the same edge the counter reaches STABLE_CYCLES.
  always_comb begin
    s_d   = sample;
    cnt_d = cnt_q;
    if (sample != s_q) begin
      cnt_d = 8'd1;
    end else if (cnt_q < STABLE) begin
      cnt_d = cnt_q + 8'd1;
    end
    accept  = (cnt_d == STABLE) && ({1'b0, s_d} != last_q);
    pattern = s_d;
    last_d  = accept ? {1'b0, s_d} : last_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= '0;
      cnt_q  <= '0;
      last_q <= LAST_TOKEN;
    end else begin
      s_q    <= s_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/seven_segment_to_priority_decoder.sv
// Decodes a stable 7-segment pattern into a priority index / one-hot word on a valid/ready port.
// Define SEGDEC_SYNC_EN to add a 2-flop input synchronizer (+2 cycles latency).
module seven_segment_to_priority_decoder
  import seg_dec_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [6:0]                             segments,
  input  logic                                   none,
  seven_segment_to_priority_decoder_if.master    dec,
  output logic                                   err,
  output logic                                   overrun
);

  logic       accept;
  logic [7:0] pattern;

  seg_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .segments (segments),
    .none     (none),
    .accept   (accept),
    .pattern  (pattern)
  );

  state_e     state_q, state_d;
  logic [2:0] index_q, index_d;
  logic [7:0] data_q, data_d;
  logic       is_none_q, is_none_d;
  logic       err_q, err_d;
  logic       overrun_q, overrun_d;
  dec_t       dec_w;
  logic       hs;
  logic       load;

  // A legal word loads when the port is free or being drained this same cycle.
  always_comb begin
    dec_w     = seg_decode(pattern);
    hs        = (state_q == EMIT) && dec.out_ready;
    load      = accept && dec_w.legal && ((state_q == TRACK) || hs);
    state_d   = state_q;
    index_d   = index_q;
    data_d    = data_q;
    is_none_d = is_none_q;
    err_d     = accept && !dec_w.legal;
    overrun_d = overrun_q;
    if (load) begin
      state_d   = EMIT;
      index_d   = dec_w.index;
      is_none_d = dec_w.is_none;
      data_d    = dec_w.is_none ? 8'h00 : (8'h01 << dec_w.index);
    end else if (hs) begin
      state_d = TRACK;
    end
    if (accept && dec_w.legal && (state_q == EMIT) && !hs) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= TRACK;
      index_q   <= '0;
      data_q    <= '0;
      is_none_q <= 1'b0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      data_q    <= data_d;
      is_none_q <= is_none_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
    end
  end

  assign dec.out_valid = (state_q == EMIT);
  assign dec.index     = index_q;
  assign dec.data      = data_q;
  assign dec.is_none   = is_none_q;
  assign err           = err_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_seven_segment_to_priority_decoder.sv
// Self-checking bench: directed cases then randomized pattern streams, compared every
// cycle against a run-length / table-lookup reference model.
module tb_seven_segment_to_priority_decoder;

  localparam int N = 4;
`ifdef SEGDEC_SYNC_EN
  localparam int LAT = N + 2;
`else
  localparam int LAT = N;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] segments = '0;
  logic       none = 1'b0;
  logic       err, overrun;

  seven_segment_to_priority_decoder_if dec ();

  seven_segment_to_priority_decoder #(
    .STABLE_CYCLES(N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .segments (segments),
    .none     (none),
    .dec      (dec),
    .err      (err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int code_tab [8] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07};

  // Reference model state
  int         m_prev, m_run, m_last;
  bit         m_valid, m_none, m_err, m_ovr;
  int         m_idx, m_data;
  int         pipe[$];

  task automatic model_reset();
    m_prev = 0; m_run = 0; m_last = -1;
    m_valid = 0; m_none = 0; m_err = 0; m_ovr = 0;
    m_idx = 0; m_data = 0;
    pipe = {};
`ifdef SEGDEC_SYNC_EN
    pipe.push_back(0);
    pipe.push_back(0);
`endif
  endtask

  function automatic bit lookup(input int p, output int idx, output bit isn);
    idx = 0; isn = 0;
    if (p == 'h80) begin isn = 1; return 1; end
    if (p >= 'h80) return 0;
    for (int i = 0; i < 8; i++) if (code_tab[i] == p) begin idx = i; return 1; end
    return 0;
  endfunction

  task automatic model_edge(input int pins, input bit rdy);
    int p, idx;
    bit isn, legal, acc, hs;
    pipe.push_back(pins);
    p = pipe.pop_front();
    if (p == m_prev) begin
      if (m_run < N) m_run++;
    end else m_run = 1;
    m_prev = p;
    acc = (m_run == N) && (p != m_last);
    if (acc) m_last = p;
    legal = lookup(p, idx, isn);
    hs = m_valid && rdy;
    m_err = acc && !legal;
    if (acc && legal) begin
      if (!m_valid || hs) begin
        m_valid = 1; m_idx = idx; m_none = isn; m_data = isn ? 0 : (1 << idx);
      end else m_ovr = 1;
    end else if (hs) m_valid = 0;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("out_valid", 8'(dec.out_valid), 8'(m_valid));
    check("index",     8'(dec.index),     8'(m_idx));
    check("data",      dec.data,          8'(m_data));
    check("is_none",   8'(dec.is_none),   8'(m_none));
    check("err",       8'(err),           8'(m_err));
    check("overrun",   8'(overrun),       8'(m_ovr));
  endtask

  task automatic step(input logic [7:0] pat, input bit rdy);
    {none, segments} = pat;
    dec.out_ready = rdy;
    @(posedge clk);
    model_edge(int'(pat), rdy);
    #1;
    vectors++;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    vectors++;
    check_model();
    check("rst_valid",   8'(dec.out_valid), 8'h00);
    check("rst_overrun", 8'(overrun),       8'h00);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int cnt_v, cnt_e, len;
    logic [7:0] pat;
    dec.out_ready = 1'b0;
    model_reset();
    #12;
    do_reset();
    check("rst_data", dec.data, 8'h00);

    // Case 1: code 6, ready high, word pulses after edge LAT
    for (int i = 1; i <= LAT + 1; i++) begin
      step(8'h7D, 1'b1);
      check("t1_valid", 8'(dec.out_valid), (i == LAT) ? 8'h01 : 8'h00);
      if (i == LAT) begin
        check("t1_index", 8'(dec.index), 8'h06);
        check("t1_data", dec.data, 8'h40);
        check("t1_none", 8'(dec.is_none), 8'h00);
      end
    end

    // Case 2: none pattern
    do_reset();
    for (int i = 0; i < LAT; i++) step(8'h80, 1'b0);
    check("t2_valid", 8'(dec.out_valid), 8'h01);
    check("t2_none", 8'(dec.is_none), 8'h01);
    check("t2_data", dec.data, 8'h00);
    check("t2_index", 8'(dec.index), 8'h00);

    // Case 3: glitch to 4 for 2 cycles yields no second word
    do_reset();
    cnt_v = 0; cnt_e = 0;
    for (int i = 0; i < 8; i++) begin step(8'h07, 1'b1); cnt_v += int'(dec.out_valid); cnt_e += int'(err); end
    for (int i = 0; i < 2; i++) begin step(8'h66, 1'b1); cnt_v += int'(dec.out_valid); cnt_e += int'(err); end
    for (int i = 0; i < 8; i++) begin step(8'h07, 1'b1); cnt_v += int'(dec.out_valid); cnt_e += int'(err); end
    check("t3_words", 8'(cnt_v), 8'h01);
    check("t3_err", 8'(cnt_e), 8'h00);

    // Case 4: illegal all-segments pattern gives one err pulse
    do_reset();
    cnt_v = 0; cnt_e = 0;
    for (int i = 0; i < LAT + 6; i++) begin step(8'h7F, 1'b1); cnt_v += int'(dec.out_valid); cnt_e += int'(err); end
    check("t4_err", 8'(cnt_e), 8'h01);
    check("t4_valid", 8'(cnt_v), 8'h00);

    // Case 5: overrun with ready low, drain, then reset clears it
    do_reset();
    for (int i = 0; i < LAT + 1; i++) step(8'h5B, 1'b0);
    for (int i = 0; i < LAT + 1; i++) step(8'h4F, 1'b0);
    check("t5_index", 8'(dec.index), 8'h02);
    check("t5_overrun", 8'(overrun), 8'h01);
    step(8'h4F, 1'b1);
    check("t5_drain", 8'(dec.out_valid), 8'h00);
    do_reset();
    check("t5_ovr_clr", 8'(overrun), 8'h00);

    // Randomized streams of held patterns with random ready and occasional reset
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 19))
        0, 1, 2:    pat = 8'h80;
        3, 4, 5, 6: pat = 8'($urandom_range(0, 255));
        default:    pat = 8'(code_tab[$urandom_range(0, 7)]);
      endcase
      len = $urandom_range(1, LAT + 3);
      for (int j = 0; j < len; j++) step(pat, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 39) == 0) begin
        #2;
        do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
